// File: rtl/cq_adapt_pkg.sv
// cq_adapt_pkg: shared constants, descriptor field offsets and FSM states for the CQ adapter.
package cq_adapt_pkg;

  // Completer-request type codes carried in the CQ descriptor
  localparam logic [3:0] REQ_MRD    = 4'b0000;
  localparam logic [3:0] REQ_MWR    = 4'b0001;
  localparam logic [3:0] REQ_IORD   = 4'b0010;
  localparam logic [3:0] REQ_IOWR   = 4'b0011;
  localparam logic [3:0] REQ_MRDLK  = 4'b0111;
  localparam logic [3:0] REQ_CFGRD0 = 4'b1000;
  localparam logic [3:0] REQ_CFGRD1 = 4'b1001;
  localparam logic [3:0] REQ_CFGWR0 = 4'b1010;
  localparam logic [3:0] REQ_CFGWR1 = 4'b1011;

  // Legacy {fmt[2:0], type[4:0]} for a 3-DW header
  localparam logic [7:0] FT_MRD    = 8'b000_00000;
  localparam logic [7:0] FT_MRDLK  = 8'b000_00001;
  localparam logic [7:0] FT_MWR    = 8'b010_00000;
  localparam logic [7:0] FT_IORD   = 8'b000_00010;
  localparam logic [7:0] FT_IOWR   = 8'b010_00010;
  localparam logic [7:0] FT_CFGRD0 = 8'b000_00100;
  localparam logic [7:0] FT_CFGWR0 = 8'b010_00100;
  localparam logic [7:0] FT_CFGRD1 = 8'b000_00101;
  localparam logic [7:0] FT_CFGWR1 = 8'b010_00101;

  // Descriptor field positions within the first 128 bits of the sop beat
  localparam int LEN_LO  = 64;
  localparam int REQ_LO  = 75;
  localparam int RID_LO  = 80;
  localparam int TAG_LO  = 96;
  localparam int BAR_LO  = 112;
  localparam int TC_LO   = 121;
  localparam int ATTR_LO = 124;

  localparam int TUSER_W    = 85;
  localparam int TUSER_DISC = 41;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BODY,
    ST_FLUSH
  } state_t;

  // Unknown request codes are forwarded as plain memory reads
  function automatic logic [7:0] req_to_fmt_type(input logic [3:0] req_type);
    case (req_type)
      REQ_MRDLK:  return FT_MRDLK;
      REQ_MWR:    return FT_MWR;
      REQ_IORD:   return FT_IORD;
      REQ_IOWR:   return FT_IOWR;
      REQ_CFGRD0: return FT_CFGRD0;
      REQ_CFGWR0: return FT_CFGWR0;
      REQ_CFGRD1: return FT_CFGRD1;
      REQ_CFGWR1: return FT_CFGWR1;
      default:    return FT_MRD;
    endcase
  endfunction

endpackage

// File: rtl/cq_desc_to_hdr.sv
// cq_desc_to_hdr: combinational CQ descriptor -> legacy TLP header rewrite.
// With CQ_ADAPT_ADDR64_EN, memory requests above 4 GB get a 4-DW header (shift 0).
module cq_desc_to_hdr
  import cq_adapt_pkg::*;
(
  input  logic [127:0] desc,
  input  logic [3:0]   first_be,
  input  logic [3:0]   last_be,
  output logic [31:0]  hdr_dw0,
  output logic [31:0]  hdr_dw1,
  output logic [31:0]  hdr_dw2,
  output logic [31:0]  hdr_dw3,
  output logic         shift,
  output logic [7:0]   bar_user
);

  logic [3:0]  req_type;
  logic [7:0]  fmt_type;
  logic [31:0] addr_lo;
  logic [31:0] addr_hi;
  logic        use_4dw;
  logic        unused_desc;

  assign req_type = desc[REQ_LO +: 4];
  assign addr_lo  = {desc[31:2], 2'b00};
  assign addr_hi  = desc[63:32];

`ifdef CQ_ADAPT_ADDR64_EN
  assign use_4dw = (req_type == REQ_MRD || req_type == REQ_MRDLK || req_type == REQ_MWR)
                   && (addr_hi != 32'h0);
`else
  assign use_4dw = 1'b0;
`endif

  // fmt[0] (bit 5 of {fmt,type}) marks the 4-DW form; only attr[1:0] fits the legacy DW0 slot
  always_comb begin
    fmt_type    = req_to_fmt_type(req_type);
    fmt_type[5] = fmt_type[5] | use_4dw;
    hdr_dw0 = {fmt_type, 1'b0, desc[TC_LO +: 3], 4'b0000, 1'b0, 1'b0,
               desc[ATTR_LO +: 2], 2'b00, desc[LEN_LO +: 10]};
    hdr_dw1 = {desc[RID_LO +: 16], desc[TAG_LO +: 8], last_be, first_be};
    hdr_dw2 = use_4dw ? addr_hi : addr_lo;
    hdr_dw3 = use_4dw ? addr_lo : 32'h0;
  end

  assign shift    = ~use_4dw;
  assign bar_user = {1'b0, desc[BAR_LO +: 3], req_type};

  assign unused_desc = ^{desc[1:0], desc[63:32], desc[74], desc[79], desc[111:104],
                         desc[120:115], desc[127:126]};

endmodule

// File: rtl/m_axis_cq_adapt_xn.sv
// m_axis_cq_adapt_xn: 128/256-bit CQ stream adapter producing legacy TLP header + realigned payload.
// Optional build macro: CQ_ADAPT_ADDR64_EN (4-DW headers for memory requests above 4 GB).
module m_axis_cq_adapt_xn
  import cq_adapt_pkg::*;
#(
  parameter int DATA_WIDTH = 256,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                     user_clk,
  input  logic                     user_reset_n,
  input  logic [DATA_WIDTH-1:0]    m_axis_cq_tdata_a,
  input  logic [DATA_WIDTH/32-1:0] m_axis_cq_tkeep_a,
  input  logic                     m_axis_cq_tlast_a,
  input  logic [TUSER_W-1:0]       m_axis_cq_tuser_a,
  input  logic                     m_axis_cq_tvalid_a,
  output logic [3:0]               m_axis_cq_tready_a,
  output logic [DATA_WIDTH-1:0]    m_axis_cq_tdata,
  output logic [KEEP_WIDTH-1:0]    m_axis_cq_tkeep,
  output logic                     m_axis_cq_tlast,
  output logic [TUSER_W-1:0]       m_axis_cq_tuser,
  output logic                     m_axis_cq_tvalid,
  input  logic [3:0]               m_axis_cq_tready
);

  localparam int W = DATA_WIDTH / 32;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] held_data;
  logic [W-1:0]          held_keep;
  logic                  disc_q;
  logic [7:0]            bar_q;

  logic [31:0]           hdr_dw0, hdr_dw1, hdr_dw2, hdr_dw3;
  logic                  hdr_shift;
  logic [7:0]            hdr_bar;
  logic [127:0]          desc_rw;
  logic [DATA_WIDTH-1:0] sop_data;

  logic                  s_cur, in_ready, in_fire, out_fire, merge_last, is_sop;
  logic [DATA_WIDTH-1:0] out_data;
  logic [W-1:0]          out_dkeep;
  logic                  out_valid, out_last, out_disc;
  logic                  unused_in;

  cq_desc_to_hdr u_desc_to_hdr (
    .desc     (m_axis_cq_tdata_a[127:0]),
    .first_be (m_axis_cq_tuser_a[3:0]),
    .last_be  (m_axis_cq_tuser_a[7:4]),
    .hdr_dw0  (hdr_dw0),
    .hdr_dw1  (hdr_dw1),
    .hdr_dw2  (hdr_dw2),
    .hdr_dw3  (hdr_dw3),
    .shift    (hdr_shift),
    .bar_user (hdr_bar)
  );

`ifdef CQ_ADAPT_ADDR64_EN
  logic s_q;

  assign s_cur   = s_q;
  assign desc_rw = hdr_shift ? {hdr_dw2, hdr_dw1, hdr_dw0, m_axis_cq_tdata_a[31:0]}
                             : {hdr_dw3, hdr_dw2, hdr_dw1, hdr_dw0};

  // Header size (and so the payload shift) is fixed by the sop beat for the whole packet
  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n)        s_q <= 1'b1;
    else if (in_fire && is_sop) s_q <= hdr_shift;
  end
`else
  logic unused_hdr;

  assign unused_hdr = ^{hdr_dw3, hdr_shift};
  assign s_cur      = 1'b1;
  assign desc_rw    = {hdr_dw2, hdr_dw1, hdr_dw0, m_axis_cq_tdata_a[31:0]};
`endif

  assign unused_in = ^{m_axis_cq_tuser_a[TUSER_W-1:TUSER_DISC+1],
                       m_axis_cq_tuser_a[TUSER_DISC-1:8], m_axis_cq_tready[3:1]};

  assign is_sop     = (state_q != ST_BODY);
  assign in_ready   = (state_q == ST_IDLE) ? 1'b1 : m_axis_cq_tready[0];
  assign in_fire    = m_axis_cq_tvalid_a & in_ready;
  assign out_fire   = out_valid & m_axis_cq_tready[0];
  assign merge_last = (state_q == ST_BODY) && s_cur && m_axis_cq_tvalid_a && m_axis_cq_tlast_a
                      && (m_axis_cq_tkeep_a == W'(1));

  assign m_axis_cq_tready_a = {4{in_ready}};

  // Sop beat: descriptor dwords replaced by the rewritten header, payload untouched
  always_comb begin
    sop_data        = m_axis_cq_tdata_a;
    sop_data[127:0] = desc_rw;
  end

  // Next state and output beat assembly from the hold register and the live input beat
  always_comb begin
    state_d   = state_q;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    out_dkeep = '0;
    out_disc  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (m_axis_cq_tvalid_a) state_d = m_axis_cq_tlast_a ? ST_FLUSH : ST_BODY;
      end
      ST_BODY: begin
        out_valid = m_axis_cq_tvalid_a;
        out_last  = merge_last;
        out_disc  = disc_q | (m_axis_cq_tvalid_a & m_axis_cq_tuser_a[TUSER_DISC]);
        out_data  = s_cur ? {m_axis_cq_tdata_a[31:0], held_data[DATA_WIDTH-1:32]} : held_data;
        out_dkeep = s_cur ? {m_axis_cq_tkeep_a[0], held_keep[W-1:1]} : held_keep;
        if (out_fire) begin
          if (merge_last)             state_d = ST_IDLE;
          else if (m_axis_cq_tlast_a) state_d = ST_FLUSH;
          else                        state_d = ST_BODY;
        end
      end
      ST_FLUSH: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_disc  = disc_q;
        out_data  = s_cur ? {32'h0, held_data[DATA_WIDTH-1:32]} : held_data;
        out_dkeep = s_cur ? {1'b0, held_keep[W-1:1]} : held_keep;
        if (m_axis_cq_tready[0]) begin
          if (m_axis_cq_tvalid_a) state_d = m_axis_cq_tlast_a ? ST_FLUSH : ST_BODY;
          else                    state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, hold register and per-packet sticky fields
  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      state_q   <= ST_IDLE;
      held_data <= '0;
      held_keep <= '0;
      disc_q    <= 1'b0;
      bar_q     <= 8'h0;
    end else begin
      state_q <= state_d;
      if (in_fire) begin
        held_data <= is_sop ? sop_data : m_axis_cq_tdata_a;
        held_keep <= m_axis_cq_tkeep_a;
        if (is_sop) begin
          bar_q  <= hdr_bar;
          disc_q <= m_axis_cq_tuser_a[TUSER_DISC];
        end else if (merge_last) begin
          disc_q <= 1'b0;
        end else begin
          disc_q <= disc_q | m_axis_cq_tuser_a[TUSER_DISC];
        end
      end else if (out_fire && out_last) begin
        disc_q <= 1'b0;
      end
    end
  end

  // Expand dword keep to byte keep
  always_comb begin
    m_axis_cq_tkeep = '0;
    for (int i = 0; i < W; i++) m_axis_cq_tkeep[4*i +: 4] = {4{out_dkeep[i]}};
  end

  // Sideband: discontinue in bit 0, BAR/type byte while a packet is in flight
  always_comb begin
    m_axis_cq_tuser    = '0;
    m_axis_cq_tuser[0] = out_disc;
    if (state_q != ST_IDLE) m_axis_cq_tuser[9:2] = bar_q;
  end

  assign m_axis_cq_tdata  = out_data;
  assign m_axis_cq_tlast  = out_last;
  assign m_axis_cq_tvalid = out_valid;

endmodule

// File: tb/tb_m_axis_cq_adapt_xn.sv
// tb_m_axis_cq_adapt_xn: directed self-checking bench for the CQ adapter (256-bit and 128-bit instances).
module tb_m_axis_cq_adapt_xn;

  logic user_clk = 1'b0;
  logic user_reset_n;

  always #5 user_clk = ~user_clk;

  // 256-bit instance
  logic [255:0] tdata_a;
  logic [7:0]   tkeep_a;
  logic         tlast_a;
  logic [84:0]  tuser_a;
  logic         tvalid_a;
  logic [3:0]   tready_a;
  logic [255:0] tdata;
  logic [31:0]  tkeep;
  logic         tlast;
  logic [84:0]  tuser;
  logic         tvalid;
  logic [3:0]   tready;

  // 128-bit instance
  logic [127:0] n_tdata_a;
  logic [3:0]   n_tkeep_a;
  logic         n_tlast_a;
  logic [84:0]  n_tuser_a;
  logic         n_tvalid_a;
  logic [3:0]   n_tready_a;
  logic [127:0] n_tdata;
  logic [15:0]  n_tkeep;
  logic         n_tlast;
  logic [84:0]  n_tuser;
  logic         n_tvalid;
  logic [3:0]   n_tready;

  int err_count   = 0;
  int check_count = 0;

  m_axis_cq_adapt_xn #(.DATA_WIDTH(256)) dut (
    .user_clk(user_clk), .user_reset_n(user_reset_n),
    .m_axis_cq_tdata_a(tdata_a), .m_axis_cq_tkeep_a(tkeep_a), .m_axis_cq_tlast_a(tlast_a),
    .m_axis_cq_tuser_a(tuser_a), .m_axis_cq_tvalid_a(tvalid_a), .m_axis_cq_tready_a(tready_a),
    .m_axis_cq_tdata(tdata), .m_axis_cq_tkeep(tkeep), .m_axis_cq_tlast(tlast),
    .m_axis_cq_tuser(tuser), .m_axis_cq_tvalid(tvalid), .m_axis_cq_tready(tready)
  );

  m_axis_cq_adapt_xn #(.DATA_WIDTH(128)) dut128 (
    .user_clk(user_clk), .user_reset_n(user_reset_n),
    .m_axis_cq_tdata_a(n_tdata_a), .m_axis_cq_tkeep_a(n_tkeep_a), .m_axis_cq_tlast_a(n_tlast_a),
    .m_axis_cq_tuser_a(n_tuser_a), .m_axis_cq_tvalid_a(n_tvalid_a), .m_axis_cq_tready_a(n_tready_a),
    .m_axis_cq_tdata(n_tdata), .m_axis_cq_tkeep(n_tkeep), .m_axis_cq_tlast(n_tlast),
    .m_axis_cq_tuser(n_tuser), .m_axis_cq_tvalid(n_tvalid), .m_axis_cq_tready(n_tready)
  );

  // Counts one comparison and reports it when observed differs from expected
  task automatic checkOutput(input string tag, input logic [255:0] actual, input logic [255:0] expected);
    check_count++;
    if (actual !== expected) begin
      err_count++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Waits for the next rising edge, drives one input beat, then returns at the falling edge
  task automatic applyStimulus(input bit narrow, input logic valid, input logic [255:0] data,
                               input logic [7:0] keep, input logic last, input logic [84:0] user);
    @(posedge user_clk);
    #1;
    if (narrow) begin
      n_tvalid_a = valid; n_tdata_a = data[127:0]; n_tkeep_a = keep[3:0];
      n_tlast_a = last; n_tuser_a = user;
    end else begin
      tvalid_a = valid; tdata_a = data; tkeep_a = keep; tlast_a = last; tuser_a = user;
    end
    @(negedge user_clk);
  endtask

  function automatic logic [127:0] make_desc(input logic [63:0] addr, input logic [10:0] len,
                                             input logic [3:0] req, input logic [15:0] rid,
                                             input logic [7:0] tag, input logic [2:0] bar);
    logic [127:0] d;
    d = '0;
    d[63:0]    = addr;
    d[74:64]   = len;
    d[78:75]   = req;
    d[95:80]   = rid;
    d[103:96]  = tag;
    d[114:112] = bar;
    return d;
  endfunction

  function automatic logic [84:0] make_user(input logic [3:0] fbe, input logic [3:0] lbe, input logic disc);
    logic [84:0] u;
    u = '0;
    u[3:0] = fbe;
    u[7:4] = lbe;
    u[41]  = disc;
    return u;
  endfunction

  logic [255:0] exp_data;

  initial begin
    user_reset_n = 1'b0;
    tvalid_a = 0; tdata_a = '0; tkeep_a = '0; tlast_a = 0; tuser_a = '0; tready = 4'h1;
    n_tvalid_a = 0; n_tdata_a = '0; n_tkeep_a = '0; n_tlast_a = 0; n_tuser_a = '0; n_tready = 4'h1;

    // Reset state
    repeat (2) @(negedge user_clk);
    checkOutput("rst_tvalid", tvalid, 0);
    checkOutput("rst_tlast", tlast, 0);
    checkOutput("rst_tkeep", tkeep, 0);
    checkOutput("rst_tdata", tdata, 0);
    checkOutput("rst_tuser", tuser, 0);
    checkOutput("rst_tready_a", tready_a, 4'hF);
    user_reset_n = 1'b1;

    // 256b MRd len 1, single beat
    applyStimulus(0, 1, {128'h0, make_desc(64'h1000, 11'd1, 4'b0000, 16'h0100, 8'h05, 3'd0)},
                  8'h0F, 1, make_user(4'hF, 4'h0, 0));
    checkOutput("mrd_latency", tvalid, 0);
    applyStimulus(0, 0, '0, 8'h0, 0, '0);
    checkOutput("mrd_tvalid", tvalid, 1);
    checkOutput("mrd_tlast", tlast, 1);
    checkOutput("mrd_tkeep", tkeep, 32'h0000_0FFF);
    checkOutput("mrd_tdata", tdata, {160'h0, 32'h0000_1000, 32'h0100_050F, 32'h0000_0001});
    checkOutput("mrd_tuser", tuser, 0);
    applyStimulus(0, 0, '0, 8'h0, 0, '0);
    checkOutput("mrd_done", tvalid, 0);

    // 256b MWr len 5, second beat carries one dword -> merged single output beat
    applyStimulus(0, 1, {32'hA3, 32'hA2, 32'hA1, 32'hA0,
                         make_desc(64'h2000, 11'd5, 4'b0001, 16'h0100, 8'h06, 3'd1)},
                  8'hFF, 0, make_user(4'hF, 4'hF, 0));
    applyStimulus(0, 1, {224'h0, 32'hA4}, 8'h01, 1, make_user(4'hF, 4'hF, 0));
    checkOutput("mwr_tvalid", tvalid, 1);
    checkOutput("mwr_tlast", tlast, 1);
    checkOutput("mwr_tkeep", tkeep, 32'hFFFF_FFFF);
    checkOutput("mwr_tdata", tdata, {32'hA4, 32'hA3, 32'hA2, 32'hA1, 32'hA0,
                                     32'h0000_2000, 32'h0100_06FF, 32'h4000_0005});
    checkOutput("mwr_tuser", tuser, 85'h44);
    applyStimulus(0, 0, '0, 8'h0, 0, '0);
    checkOutput("mwr_done", tvalid, 0);

    // 128b MWr len 1
    applyStimulus(1, 1, {128'h0, make_desc(64'h3000, 11'd1, 4'b0001, 16'h0100, 8'h07, 3'd2)},
                  8'h0F, 0, make_user(4'hF, 4'h0, 0));
    checkOutput("n_latency", n_tvalid, 0);
    applyStimulus(1, 1, {224'h0, 32'hA0}, 8'h01, 1, make_user(4'hF, 4'h0, 0));
    checkOutput("n_tvalid", n_tvalid, 1);
    checkOutput("n_tlast", n_tlast, 1);
    checkOutput("n_tkeep", n_tkeep, 16'hFFFF);
    checkOutput("n_tdata", n_tdata, {32'hA0, 32'h0000_3000, 32'h0100_070F, 32'h4000_0001});
    checkOutput("n_tuser", n_tuser, 85'h84);
    applyStimulus(1, 0, '0, 8'h0, 0, '0);
    checkOutput("n_done", n_tvalid, 0);

    // MRd above 4 GB
    applyStimulus(0, 1, {128'h0, make_desc(64'h1_0000_0040, 11'd1, 4'b0000, 16'h0100, 8'h08, 3'd0)},
                  8'h0F, 1, make_user(4'hF, 4'h0, 0));
    applyStimulus(0, 0, '0, 8'h0, 0, '0);
    checkOutput("a64_tvalid", tvalid, 1);
`ifdef CQ_ADAPT_ADDR64_EN
    checkOutput("a64_tkeep", tkeep, 32'h0000_FFFF);
    checkOutput("a64_tdata", tdata, {128'h0, 32'h0000_0040, 32'h0000_0001, 32'h0100_080F, 32'h2000_0001});
`else
    checkOutput("a64_tkeep", tkeep, 32'h0000_0FFF);
    checkOutput("a64_tdata", tdata, {160'h0, 32'h0000_0040, 32'h0100_080F, 32'h0000_0001});
`endif
    applyStimulus(0, 0, '0, 8'h0, 0, '0);

    // Back-pressure for 3 cycles mid-packet, discontinue on input beat 1
    applyStimulus(0, 1, {32'hA3, 32'hA2, 32'hA1, 32'hA0,
                         make_desc(64'h4000, 11'd13, 4'b0001, 16'h0100, 8'h09, 3'd0)},
                  8'hFF, 0, make_user(4'hF, 4'hF, 0));
    tready = 4'h0;
    applyStimulus(0, 1, {32'hAB, 32'hAA, 32'hA9, 32'hA8, 32'hA7, 32'hA6, 32'hA5, 32'hA4},
                  8'hFF, 0, make_user(4'hF, 4'hF, 1));
    exp_data = {32'hA4, 32'hA3, 32'hA2, 32'hA1, 32'hA0, 32'h0000_4000, 32'h0100_09FF, 32'h4000_000D};
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        @(posedge user_clk);
        @(negedge user_clk);
      end
      checkOutput("bp_tready_a", tready_a, 4'h0);
      checkOutput("bp_tvalid", tvalid, 1);
      checkOutput("bp_tdata", tdata, exp_data);
      checkOutput("bp_tlast", tlast, 0);
      checkOutput("bp_tuser", tuser, 85'h5);
    end
    tready = 4'h1;
    applyStimulus(0, 1, {224'h0, 32'hAC}, 8'h01, 1, make_user(4'hF, 4'hF, 0));
    checkOutput("bp2_tdata", tdata, {32'hAC, 32'hAB, 32'hAA, 32'hA9, 32'hA8, 32'hA7, 32'hA6, 32'hA5});
    checkOutput("bp2_tlast", tlast, 1);
    checkOutput("bp2_tkeep", tkeep, 32'hFFFF_FFFF);
    checkOutput("bp2_tuser", tuser, 85'h5);
    applyStimulus(0, 0, '0, 8'h0, 0, '0);
    checkOutput("bp_done", tvalid, 0);

    // Back-to-back single-beat MRds with no gap
    applyStimulus(0, 1, {128'h0, make_desc(64'h5000, 11'd1, 4'b0000, 16'h0100, 8'h0A, 3'd0)},
                  8'h0F, 1, make_user(4'hF, 4'h0, 0));
    applyStimulus(0, 1, {128'h0, make_desc(64'h6000, 11'd1, 4'b0000, 16'h0100, 8'h0B, 3'd0)},
                  8'h0F, 1, make_user(4'hF, 4'h0, 0));
    checkOutput("b2b_a_tvalid", tvalid, 1);
    checkOutput("b2b_a_tready_a", tready_a, 4'hF);
    checkOutput("b2b_a_tdata", tdata, {160'h0, 32'h0000_5000, 32'h0100_0A0F, 32'h0000_0001});
    checkOutput("b2b_a_tuser", tuser, 0);
    applyStimulus(0, 0, '0, 8'h0, 0, '0);
    checkOutput("b2b_b_tvalid", tvalid, 1);
    checkOutput("b2b_b_tlast", tlast, 1);
    checkOutput("b2b_b_tdata", tdata, {160'h0, 32'h0000_6000, 32'h0100_0B0F, 32'h0000_0001});
    applyStimulus(0, 0, '0, 8'h0, 0, '0);
    checkOutput("b2b_done", tvalid, 0);

    // Reset pulsed in the middle of a discontinued MWr
    applyStimulus(0, 1, {32'hA3, 32'hA2, 32'hA1, 32'hA0,
                         make_desc(64'h8000, 11'd13, 4'b0001, 16'h0100, 8'h0D, 3'd0)},
                  8'hFF, 0, make_user(4'hF, 4'hF, 1));
    applyStimulus(0, 1, {32'hAB, 32'hAA, 32'hA9, 32'hA8, 32'hA7, 32'hA6, 32'hA5, 32'hA4},
                  8'hFF, 0, make_user(4'hF, 4'hF, 0));
    checkOutput("rmid_tvalid_before", tvalid, 1);
    #1;
    user_reset_n = 1'b0;
    tvalid_a = 1'b0;
    #1;
    checkOutput("rmid_tvalid", tvalid, 0);
    checkOutput("rmid_tlast", tlast, 0);
    checkOutput("rmid_tready_a", tready_a, 4'hF);
    @(negedge user_clk);
    user_reset_n = 1'b1;
    applyStimulus(0, 1, {128'h0, make_desc(64'h7000, 11'd1, 4'b0000, 16'h0100, 8'h0C, 3'd0)},
                  8'h0F, 1, make_user(4'hF, 4'h0, 0));
    checkOutput("rpost_latency", tvalid, 0);
    applyStimulus(0, 0, '0, 8'h0, 0, '0);
    checkOutput("rpost_tvalid", tvalid, 1);
    checkOutput("rpost_tdata", tdata, {160'h0, 32'h0000_7000, 32'h0100_0C0F, 32'h0000_0001});
    checkOutput("rpost_tuser", tuser, 0);
    checkOutput("rpost_tkeep", tkeep, 32'h0000_0FFF);
    applyStimulus(0, 0, '0, 8'h0, 0, '0);
    checkOutput("rpost_done", tvalid, 0);

    $display("Result: errors=%0d of %0d checks", err_count, check_count);
    $finish;
  end

endmodule
